// File: rtl/crc9_check_if.sv
// rtl/crc9_check_if.sv - request/result bundle for the 9-bit cyclic parity checker
interface crc9_check_if #(
  parameter int N     = 64,
  parameter int CNT_W = 16
);
  logic             start;
  logic             shift;
  logic [N-1:0]     data_in;
  logic [8:0]       parity_in;
  logic             busy;
  logic             done;
  logic             error;
  logic [8:0]       syndrome;
  logic [10:0]      count;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output start, shift, data_in, parity_in,
    input  busy, done, error, syndrome, count, err_cnt
  );

  modport slave (
    input  start, shift, data_in, parity_in,
    output busy, done, error, syndrome, count, err_cnt
  );
endinterface

// File: rtl/crc9_check.sv
// rtl/crc9_check.sv - serial x^9+x^4+1 parity re-computation and syndrome checker
module crc9_check #(
  parameter int N     = 64,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  crc9_check_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // The step taken while count equals this value is the last one of a check.
  localparam logic [10:0] LAST_STEP = 11'(N + 8);
  localparam int          IDX_W     = (N > 1) ? $clog2(N) : 1;

  state_t           state_q, state_d;
  logic [N-1:0]     data_q, data_d;
  logic [8:0]       parity_q, parity_d;
  logic [8:0]       lfsr_q, lfsr_d;
  logic [8:0]       syndrome_q, syndrome_d;
  logic [10:0]      count_q, count_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [IDX_W-1:0] bit_idx;
  logic             data_bit;
  logic [8:0]       lfsr_next;
  logic [8:0]       syndrome_next;

  // Serial input bit (data MSB first, then zero flush) and one LFSR step
  always_comb begin
    bit_idx       = IDX_W'(N - 1 - int'(count_q));
    data_bit      = (count_q < 11'(N)) ? data_q[bit_idx] : 1'b0;
    lfsr_next     = {data_bit ^ lfsr_q[0], lfsr_q[8:6], lfsr_q[5] ^ lfsr_q[0], lfsr_q[4:1]};
    syndrome_next = lfsr_next ^ parity_q;
  end

  // Next-state logic for the check sequencer and all its registers
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    parity_d   = parity_q;
    lfsr_d     = lfsr_q;
    syndrome_d = syndrome_q;
    count_d    = count_q;
    error_d    = error_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = SHIFT;
          data_d   = bus.data_in;
          parity_d = bus.parity_in;
          lfsr_d   = 9'd0;
          count_d  = 11'd0;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        if (bus.shift) begin
          lfsr_d  = lfsr_next;
          count_d = count_q + 11'd1;
          if (count_q == LAST_STEP) begin
            state_d    = DONE;
            syndrome_d = syndrome_next;
            error_d    = |syndrome_next;
            if ((|syndrome_next) && (err_cnt_q != {CNT_W{1'b1}})) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and result registers; reset aborts any check in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      parity_q   <= 9'd0;
      lfsr_q     <= 9'd0;
      syndrome_q <= 9'd0;
      count_q    <= 11'd0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      lfsr_q     <= lfsr_d;
      syndrome_q <= syndrome_d;
      count_q    <= count_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.syndrome = syndrome_q;
  assign bus.count    = count_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_crc9_check.sv
// tb/tb_crc9_check.sv - self-checking bench for crc9_check
module tb_crc9_check;
  localparam int N = 64;

  typedef struct {
    logic [63:0] data;
    logic [8:0]  parity;
    int          mode;
    logic [8:0]  exp_syn;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crc9_check_if #(.N(N), .CNT_W(16)) bus ();
  crc9_check_if #(.N(N), .CNT_W(2))  bus2 ();

  assign bus2.start     = bus.start;
  assign bus2.shift     = bus.shift;
  assign bus2.data_in   = bus.data_in;
  assign bus2.parity_in = bus.parity_in;

  crc9_check #(.N(N), .CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(bus));
  crc9_check #(.N(N), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(bus2));

  int n_cmp = 0;
  int n_bad = 0;
  int model_errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Parity = (D(x) * x^9) mod (x^9 + x^4 + 1); register bit i holds the x^(8-i) coefficient.
  function automatic logic [8:0] ref_parity(input logic [63:0] d);
    logic [72:0] m;
    logic [8:0]  p;
    m = {d, 9'b0};
    for (int i = 72; i >= 9; i--) begin
      if (m[i]) m[i-:10] = m[i-:10] ^ 10'b10_0001_0001;
    end
    for (int k = 0; k < 9; k++) p[k] = m[8-k];
    return p;
  endfunction

  // Runs until done; mode 0: shift=1, 1: shift toggles 1,0,.. with start on idle cycles, 2: random.
  task automatic run_steps(input int mode, input string name, output bit got_done);
    int en;
    bit s;
    en = 0;
    got_done = 0;
    for (int c = 0; c < 400; c++) begin
      case (mode)
        0:       s = 1'b1;
        1:       s = (c % 2 == 0);
        default: s = 1'($urandom_range(0, 1));
      endcase
      bus.shift = s;
      if (mode == 1) bus.start = ~s;
      else if (mode != 0) bus.start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s) en++;
      if (bus.done) begin
        got_done = 1;
        check({name, " steps"}, 64'(en), 64'(N + 9));
        break;
      end
      check({name, " count"}, 64'(bus.count), 64'(en));
      check({name, " busy"}, 64'(bus.busy), 64'd1);
    end
    if (!got_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got no done expected done within 400 cycles", name);
    end
  endtask

  task automatic check_results(input string name, input logic [8:0] exp_syn);
    int sat;
    if (exp_syn != 9'd0) model_errs++;
    sat = (model_errs > 3) ? 3 : model_errs;
    check({name, " syndrome"}, 64'(bus.syndrome), 64'(exp_syn));
    check({name, " error"}, 64'(bus.error), 64'(exp_syn != 9'd0));
    check({name, " count_done"}, 64'(bus.count), 64'(N + 9));
    check({name, " busy_done"}, 64'(bus.busy), 64'd0);
    check({name, " err_cnt"}, 64'(bus.err_cnt), 64'(model_errs));
    check({name, " err_cnt_sat"}, 64'(bus2.err_cnt), 64'(sat));
  endtask

  task automatic do_check(input logic [63:0] d, input logic [8:0] p, input int mode,
                          input logic [8:0] exp_syn, input string name);
    bit got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.data_in = d;
    bus.parity_in = p;
    bus.shift = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({name, " accept_busy"}, 64'(bus.busy), 64'd1);
    run_steps(mode, name, got);
    bus.start = 1'b0;
    if (got) begin
      check_results(name, exp_syn);
      @(negedge clk);
      check({name, " done_pulse"}, 64'(bus.done), 64'd0);
      check({name, " idle_busy"}, 64'(bus.busy), 64'd0);
      check({name, " syn_held"}, 64'(bus.syndrome), 64'(exp_syn));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vecs[7];
    logic [63:0] bd[6];
    logic [8:0]  bp[6];
    logic [8:0]  bs[6];
    bit          got;
    int          seen;

    vecs[0] = '{64'h0, 9'h000, 0, 9'h000, "T2_zero"};
    vecs[1] = '{64'h1, 9'h110, 0, 9'h000, "T3_ok"};
    vecs[2] = '{64'h1, 9'h000, 0, 9'h110, "T3_err"};
    vecs[3] = '{64'h2, 9'h088, 0, 9'h000, "T4_ok"};
    vecs[4] = '{64'h3, 9'h088, 2, 9'h110, "T4_flip"};
    vecs[5] = '{64'h1, 9'h000, 1, 9'h110, "T5_toggle_err"};
    vecs[6] = '{64'h1, 9'h110, 1, 9'h000, "T5_toggle_ok"};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.shift = 1'b0;
    bus.data_in = '0;
    bus.parity_in = 9'd0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset error", 64'(bus.error), 64'd0);
    check("reset syndrome", 64'(bus.syndrome), 64'd0);
    check("reset count", 64'(bus.count), 64'd0);
    check("reset err_cnt", 64'(bus.err_cnt), 64'd0);
    check("reset err_cnt_sat", 64'(bus2.err_cnt), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_check(vecs[i].data, vecs[i].parity, vecs[i].mode, vecs[i].exp_syn, vecs[i].name);
    end

    // T1: reset in the middle of a check
    @(negedge clk);
    bus.start = 1'b1;
    bus.data_in = 64'hDEAD_BEEF_0123_4567;
    bus.parity_in = 9'h1A5;
    bus.shift = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    check("T1 pre_busy", 64'(bus.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("T1 busy", 64'(bus.busy), 64'd0);
    check("T1 done", 64'(bus.done), 64'd0);
    check("T1 syndrome", 64'(bus.syndrome), 64'd0);
    check("T1 error", 64'(bus.error), 64'd0);
    check("T1 count", 64'(bus.count), 64'd0);
    check("T1 err_cnt", 64'(bus.err_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_errs = 0;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("T1 no_done_after", 64'(seen), 64'd0);

    // T6: start held high across DONE, one good check then five bad ones
    for (int i = 0; i < 6; i++) begin
      bd[i] = {$urandom, $urandom};
      bs[i] = (i == 0) ? 9'd0 : 9'(($urandom_range(1, 511)));
      bp[i] = ref_parity(bd[i]) ^ bs[i];
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.shift = 1'b1;
    bus.data_in = bd[0];
    bus.parity_in = bp[0];
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("T6 busy_after_accept", 64'(bus.busy), 64'd1);
      check("T6 single_pulse", 64'(bus.done), 64'd0);
      run_steps(0, "T6", got);
      if (!got) break;
      check_results("T6", bs[i]);
      if (i < 5) begin
        bus.data_in = bd[i+1];
        bus.parity_in = bp[i+1];
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("T6 final_done", 64'(bus.done), 64'd0);
    check("T6 final_sat", 64'(bus2.err_cnt), 64'd3);

    // Random checks against the polynomial-division model
    for (int r = 0; r < 10; r++) begin
      logic [63:0] d;
      logic [8:0]  p;
      d = {$urandom, $urandom};
      p = ($urandom_range(0, 1) == 1) ? 9'($urandom) : ref_parity(d);
      do_check(d, p, 2, ref_parity(d) ^ p, "RND");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
